// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, default sizing and counter-width helper for the SPI byte master
package spi_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam int N_DEF = 8;
  localparam int CLK_DIV_DEF = 4;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: emits sclk rise/fall strobes every CLK_DIV clks while enabled
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);
  localparam int W = cnt_w(CLK_DIV);
  logic [W-1:0] r_cnt;
  logic         r_ph;
  logic         w_tick;
  assign w_tick = i_en && (r_cnt == W'(CLK_DIV - 1));
  assign o_rise = w_tick && !r_ph;
  assign o_fall = w_tick && r_ph;
  // half-period counter; phase flips each tick, held cleared while disabled so the first tick is a rise
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_ph  <= ~r_ph;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 full-duplex SPI master, one N-bit word per en request (SPI_MSB_FIRST_EN selects MSB-first)
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] datain,
  input  logic         miso,
  output logic [N-1:0] dataout,
  output logic         done,
  output logic         mosi,
  output logic         cs,
  output logic         sclk
);
  localparam int BW = cnt_w(N);
  state_t        r_state;
  logic [N-1:0]  r_tx;
  logic [N-1:0]  r_rx;
  logic [N-1:0]  r_dataout;
  logic [BW-1:0] r_bit;
  logic          r_cs;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_done;
  logic          w_rise;
  logic          w_fall;
  logic [N-1:0]  w_tx_next;
  logic [N-1:0]  w_rx_next;
  logic          w_first;
  logic          w_next_bit;
`ifdef SPI_MSB_FIRST_EN
  assign w_first    = datain[N-1];
  assign w_tx_next  = r_tx << 1;
  assign w_next_bit = w_tx_next[N-1];
  assign w_rx_next  = {r_rx[N-2:0], miso};
`else
  assign w_first    = datain[0];
  assign w_tx_next  = r_tx >> 1;
  assign w_next_bit = w_tx_next[0];
  assign w_rx_next  = {miso, r_rx[N-1:1]};
`endif
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state == XFER),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  // transfer FSM: all pin-facing outputs are registered so cs/sclk never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_dataout <= '0;
      r_bit     <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (en) begin
          r_tx    <= datain;
          r_rx    <= '0;
          r_bit   <= '0;
          r_cs    <= 1'b0;
          r_mosi  <= w_first;
          r_state <= XFER;
        end
        XFER: if (w_rise) begin
          r_sclk <= 1'b1;
          r_rx   <= w_rx_next;
        end else if (w_fall) begin
          r_sclk <= 1'b0;
          r_tx   <= w_tx_next;
          r_mosi <= w_next_bit;
          if (r_bit == BW'(N - 1)) begin
            r_cs      <= 1'b1;
            r_done    <= 1'b1;
            r_dataout <= r_rx;
            r_mosi    <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        DONE: if (!en) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign dataout = r_dataout;
  assign done    = r_done;
  assign mosi    = r_mosi;
  assign cs      = r_cs;
  assign sclk    = r_sclk;
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: scoreboard bench for spi_byte_master (N=8, CLK_DIV=4), LSB- or MSB-first build
module tb_spi_byte_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       miso = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [7:0] dataout;
  logic       done;
  logic       mosi;
  logic       cs;
  logic       sclk;

  always #5 clk = ~clk;

  spi_byte_master #(.N(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .datain(datain), .miso(miso),
    .dataout(dataout), .done(done), .mosi(mosi), .cs(cs), .sclk(sclk)
  );

  int checks = 0;
  int failures = 0;
  logic       exp_mosi[$];
  logic [7:0] exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected mosi sequences, first bit in [7]
`ifdef SPI_MSB_FIRST_EN
  logic [7:0] seq1 = 8'b10110110;
  logic [7:0] seq2 = 8'b01101011;
  function automatic int spos(input int i); return 7 - i; endfunction
`else
  logic [7:0] seq1 = 8'b01101101;
  logic [7:0] seq2 = 8'b11010110;
  function automatic int spos(input int i); return i; endfunction
`endif

  task automatic push_bits(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) exp_mosi.push_back(seq[7-i]);
  endtask

  // slave: first bit on cs fall, next bit after each sclk fall
  logic [7:0] sbyte = 8'h00;
  int sidx = 0;
  always @(negedge cs) begin
    sidx = 0;
    miso = sbyte[spos(0)];
  end
  always @(negedge sclk) if (!cs) begin
    sidx++;
    if (sidx < 8) miso = sbyte[spos(sidx)];
  end

  // monitor: pops expectations on sclk rise, done rise and cs rise
  logic p_sclk = 1'b0, p_cs = 1'b1, p_done = 1'b0;
  int cs_low = 0;
  int rises = 0;
  always @(negedge clk) begin
    if (!cs && p_cs) begin
      cs_low = 0;
      rises = 0;
    end
    if (!cs) cs_low++;
    if (!reset) begin
      if (sclk && !p_sclk) begin
        rises++;
        if (exp_mosi.size() == 0) begin
          checks++; failures++;
          $display("FAIL mosi_extra_rise: got sclk rise, expected none");
        end else chk("mosi_bit", {31'd0, mosi}, {31'd0, exp_mosi.pop_front()});
      end
      if (done && !p_done) begin
        if (exp_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_extra: got done rise, expected none");
        end else chk("dataout", {24'd0, dataout}, {24'd0, exp_data.pop_front()});
      end
      if (cs && !p_cs) begin
        chk("cs_low_clks", cs_low, 64);
        chk("sclk_pulses", rises, 8);
      end
    end
    p_sclk = sclk;
    p_cs = cs;
    p_done = done;
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", {31'd0, done}, 1);
  endtask

  initial begin
    int n, k;
    logic ps;
    repeat (100) begin
      @(negedge clk);
      chk("rst_cs", {31'd0, cs}, 1);
      chk("rst_sclk", {31'd0, sclk}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_dataout", {24'd0, dataout}, 0);
    end
    reset = 1'b0;
    // abort after the third sclk rise
    @(negedge clk);
    datain = 8'hB6;
    sbyte = 8'hA9;
    push_bits(seq1, 3);
    en = 1'b1;
    n = 0; k = 0; ps = 1'b0;
    while (n < 3 && k < 500) begin
      @(negedge clk);
      k++;
      if (sclk && !ps) n++;
      ps = sclk;
    end
    chk("abort_rises", n, 3);
    #1 reset = 1'b1;
    en = 1'b0;
    @(negedge clk);
    chk("abort_cs", {31'd0, cs}, 1);
    chk("abort_sclk", {31'd0, sclk}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_dataout", {24'd0, dataout}, 0);
    @(negedge clk);
    reset = 1'b0;
    // transfer 1, datain changed mid-transfer, en held after done
    @(negedge clk);
    datain = 8'hB6;
    sbyte = 8'hA9;
    push_bits(seq1, 8);
    exp_data.push_back(8'hA9);
    en = 1'b1;
    repeat (6) @(negedge clk);
    datain = 8'h00;
    wait_done();
    repeat (20) begin
      @(negedge clk);
      chk("hold_done", {31'd0, done}, 1);
      chk("hold_sclk", {31'd0, sclk}, 0);
      chk("hold_cs", {31'd0, cs}, 1);
      chk("hold_dataout", {24'd0, dataout}, 8'hA9);
    end
    en = 1'b0;
    @(negedge clk);
    chk("done_drop", {31'd0, done}, 0);
    // transfer 2, en dropped mid-transfer
    @(negedge clk);
    datain = 8'h6B;
    sbyte = 8'hAB;
    push_bits(seq2, 8);
    exp_data.push_back(8'hAB);
    en = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_after_en_low", {31'd0, done}, 0);
    repeat (10) begin
      @(negedge clk);
      chk("idle_cs", {31'd0, cs}, 1);
    end
    chk("final_dataout", {24'd0, dataout}, 8'hAB);
    chk("mosi_queue_left", exp_mosi.size(), 0);
    chk("data_queue_left", exp_data.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
